// File: rtl/output_deskewer.sv
// output_deskewer: realigns skewed column sums from the bottom of the systolic
// array into whole rows, buffers them in a small FIFO and hands them to the
// result store with matrix framing (row index, last flag, done pulse).
module output_deskewer #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH  = MATRIX_SIZE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_sum,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
  output logic [$clog2(MATRIX_SIZE):0]          out_row_idx,
  output logic                                  out_last,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int unsigned IDX_W = $clog2(MATRIX_SIZE) + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + MATRIX_SIZE + 1);

  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned;
  logic                                  aligned_valid;
  logic [SUM_W-1:0]                      inflight;

  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0]                      mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]                      rd_ptr;
  logic [PTR_W-1:0]                      wr_ptr;
  logic [CNT_W-1:0]                      count;
  logic [IDX_W-1:0]                      row_ctr;
  logic                                  full_c;
  logic                                  pop_c;
  logic                                  push_c;

  // Per-column delay lines: column j waits N-1-j cycles, the last column passes straight through
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    if (j == MATRIX_SIZE - 1) begin : g_pass
      assign aligned[j] = in_sum[j];
    end else begin : g_dly
      localparam int unsigned LEN = MATRIX_SIZE - 1 - j;
      logic [LEN-1:0][DATA_SIZE-1:0] line;

      // Shift column j down its delay line
      always_ff @(posedge clk) begin
        if (reset) begin
          line <= '0;
        end else begin
          line[0] <= in_sum[j];
          for (int unsigned i = 1; i < LEN; i++) begin
            line[i] <= line[i-1];
          end
        end
      end

      assign aligned[j] = line[LEN-1];
    end
  end

  // Row-valid tracking: a row is complete N-1 cycles after its column 0 arrived
  if (MATRIX_SIZE == 1) begin : g_novsr
    assign aligned_valid = in_valid;
    assign inflight      = '0;
  end else begin : g_vsr
    logic [MATRIX_SIZE-2:0] vsr;

    // Shift in_valid along with the skew
    always_ff @(posedge clk) begin
      if (reset) begin
        vsr <= '0;
      end else begin
        vsr <= (MATRIX_SIZE-1)'({vsr, in_valid});
      end
    end

    // Count rows still being assembled, for the advisory in_ready
    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < MATRIX_SIZE - 1; i++) begin
        inflight = inflight + SUM_W'(vsr[i]);
      end
    end

    assign aligned_valid = vsr[MATRIX_SIZE-2];
  end

  assign full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop_c     = out_valid && out_ready;
  assign push_c    = aligned_valid && (!full_c || pop_c);
  assign in_ready  = (SUM_W'(count) + inflight) < SUM_W'(FIFO_DEPTH);

  assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
  assign out_row_idx = out_valid ? mem_tag[rd_ptr] : '0;
  assign out_last    = out_valid && (mem_tag[rd_ptr] == IDX_W'(MATRIX_SIZE - 1));

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO storage: aligned row plus its row-within-matrix tag
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem_data[wr_ptr] <= aligned;
      mem_tag[wr_ptr]  <= row_ctr;
    end
  end

  // FIFO control, row framing, overflow and done
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      row_ctr  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_c) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      // Dropped rows still advance the tag so matrix framing survives an overflow
      if (aligned_valid) begin
        row_ctr <= (row_ctr == IDX_W'(MATRIX_SIZE - 1)) ? '0 : row_ctr + IDX_W'(1);
      end
      if (aligned_valid && !push_c) begin
        overflow <= 1'b1;
      end
      done <= pop_c && out_last;
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_output_deskewer.sv
// Bench for output_deskewer: directed scenarios with literal expectations,
// randomized traffic against a queue-based row model, and a streaming run
// on a 4x4 instance.
module tb_output_deskewer;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 2;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                in_valid;
  logic [N-1:0][W-1:0] in_sum;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] out_data;
  logic [$clog2(N):0]  out_row_idx;
  logic                out_last;
  logic                done;
  logic                overflow;

  logic                 b_reset;
  logic                 b_in_valid;
  logic [NB-1:0][W-1:0] b_in_sum;
  logic                 b_in_ready;
  logic                 b_out_valid;
  logic                 b_out_ready;
  logic [NB-1:0][W-1:0] b_out_data;
  logic [$clog2(NB):0]  b_out_row_idx;
  logic                 b_out_last;
  logic                 b_done;
  logic                 b_overflow;

  output_deskewer #(.MATRIX_SIZE(N), .DATA_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last),
    .done(done), .overflow(overflow)
  );

  output_deskewer #(.MATRIX_SIZE(NB), .DATA_SIZE(W), .FIFO_DEPTH(NB)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_sum(b_in_sum),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_row_idx(b_out_row_idx), .out_last(b_out_last),
    .done(b_done), .overflow(b_overflow)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rows assembled column by column, then a bounded queue
  typedef struct { logic [N-1:0][W-1:0] d; int tag; } mrow_t;
  typedef struct { logic [N-1:0][W-1:0] d; int age; } mpend_t;
  mrow_t  mq[$];
  mpend_t mp[$];
  int     m_ctr  = 0;
  bit     m_ovf  = 1'b0;
  bit     m_done = 1'b0;

  task automatic model_step();
    bit     pop;
    bit     complete;
    bit     full_before;
    int     head_tag;
    mrow_t  nr;
    mpend_t p;
    if (reset === 1'b1) begin
      mq.delete();
      mp.delete();
      m_ctr  = 0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      return;
    end
    pop      = (mq.size() != 0) && (out_ready === 1'b1);
    head_tag = pop ? mq[0].tag : -1;
    if (in_valid === 1'b1) begin
      p.d   = '0;
      p.age = 0;
      mp.push_back(p);
    end
    foreach (mp[i]) mp[i].d[mp[i].age] = in_sum[mp[i].age];
    complete = 1'b0;
    nr.d     = '0;
    nr.tag   = 0;
    if (mp.size() != 0 && mp[0].age == int'(N) - 1) begin
      nr.d     = mp[0].d;
      nr.tag   = m_ctr;
      complete = 1'b1;
      void'(mp.pop_front());
      m_ctr = (m_ctr + 1) % int'(N);
    end
    foreach (mp[i]) mp[i].age++;
    full_before = (mq.size() >= int'(D));
    if (pop) void'(mq.pop_front());
    if (complete) begin
      if (!full_before || pop) mq.push_back(nr);
      else m_ovf = 1'b1;
    end
    m_done = pop && (head_tag == int'(N) - 1);
  endtask

  // Compare mid-cycle against the model, then advance the model over the coming edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", out_valid, mq.size() != 0);
      chk("m_in_ready", in_ready, (mq.size() + mp.size()) < int'(D));
      chk("m_done", done, m_done);
      chk("m_overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        chk("m_data", out_data, mq[0].d);
        chk("m_idx", out_row_idx, mq[0].tag);
        chk("m_last", out_last, mq[0].tag == int'(N) - 1);
      end
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] s0, input logic [W-1:0] s1);
    in_valid  = v;
    in_sum[0] = s0;
    in_sum[1] = s1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int ready_pct;
  int b_rows;
  int b_dones;

  initial begin
    b_reset     = 1'b1;
    b_in_valid  = 1'b0;
    b_in_sum    = '0;
    b_out_ready = 1'b1;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Two rows, sink always ready
    out_ready = 1'b1;
    drive(1, 32'h11, 32'h0);  tick();
    drive(1, 32'h12, 32'h21); tick();
    drive(0, 32'h0,  32'h22);
    chk("t1_valid_c2", out_valid, 1'b1);
    chk("t1_data_c2", out_data, {32'h21, 32'h11});
    chk("t1_idx_c2", out_row_idx, 2'd0);
    chk("t1_last_c2", out_last, 1'b0);
    tick();
    drive(0, 32'h0, 32'h0);
    chk("t1_data_c3", out_data, {32'h22, 32'h12});
    chk("t1_idx_c3", out_row_idx, 2'd1);
    chk("t1_last_c3", out_last, 1'b1);
    chk("t1_done_c3", done, 1'b0);
    tick();
    chk("t1_done_c4", done, 1'b1);
    chk("t1_valid_c4", out_valid, 1'b0);
    tick();
    chk("t1_done_c5", done, 1'b0);

    // Backpressure, then a row pushed into a full FIFO
    do_reset();
    drive(1, 32'h11, 32'h0);  tick();
    drive(1, 32'h12, 32'h21); tick();
    drive(0, 32'h0,  32'h22);
    chk("bp_valid_c2", out_valid, 1'b1);
    chk("bp_head_c2", out_data, {32'h21, 32'h11});
    chk("bp_in_ready_c2", in_ready, 1'b0);
    tick();
    drive(1, 32'h13, 32'h0);
    chk("bp_head_c3", out_data, {32'h21, 32'h11});
    chk("bp_in_ready_c3", in_ready, 1'b0);
    tick();
    drive(0, 32'h0, 32'h23);
    tick();
    drive(0, 32'h0, 32'h0);
    chk("ov_flag_c5", overflow, 1'b1);
    chk("ov_head_c5", out_data, {32'h21, 32'h11});
    chk("ov_idx_c5", out_row_idx, 2'd0);
    out_ready = 1'b1;
    tick();
    chk("ov_head_c6", out_data, {32'h22, 32'h12});
    chk("ov_idx_c6", out_row_idx, 2'd1);
    tick();
    chk("ov_done_c7", done, 1'b1);
    chk("ov_empty_c7", out_valid, 1'b0);
    drive(1, 32'h14, 32'h0);  tick();
    drive(0, 32'h0,  32'h24); tick();
    drive(0, 32'h0,  32'h0);
    chk("ov_next_data", out_data, {32'h24, 32'h14});
    chk("ov_next_idx", out_row_idx, 2'd1);
    chk("ov_sticky", overflow, 1'b1);
    tick();
    chk("ov_next_done", done, 1'b1);

    // Full FIFO with a pop on the same edge a row completes
    do_reset();
    drive(1, 32'h11, 32'h0);  tick();
    drive(1, 32'h12, 32'h21); tick();
    drive(1, 32'h13, 32'h22); tick();
    drive(0, 32'h0,  32'h23);
    chk("sim_head_c3", out_data, {32'h21, 32'h11});
    out_ready = 1'b1;
    tick();
    drive(0, 32'h0, 32'h0);
    out_ready = 1'b0;
    chk("sim_overflow_c4", overflow, 1'b0);
    chk("sim_head_c4", out_data, {32'h22, 32'h12});
    tick();
    chk("sim_head_c5", out_data, {32'h22, 32'h12});
    chk("sim_in_ready_c5", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("sim_head_c6", out_data, {32'h23, 32'h13});
    chk("sim_idx_c6", out_row_idx, 2'd0);
    tick();
    chk("sim_empty_c7", out_valid, 1'b0);

    // Reset with one row buffered and one still in flight
    do_reset();
    drive(1, 32'h31, 32'h0);  tick();
    drive(1, 32'h32, 32'h41); tick();
    drive(0, 32'h0,  32'h42);
    chk("rm_valid_pre", out_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_valid", out_valid, 1'b0);
    chk("rm_overflow", overflow, 1'b0);
    chk("rm_done", done, 1'b0);
    drive(1, 32'h51, 32'h0);  tick();
    drive(0, 32'h0,  32'h61);
    chk("rm_latency", out_valid, 1'b0);
    tick();
    drive(0, 32'h0, 32'h0);
    chk("rm_fresh_valid", out_valid, 1'b1);
    chk("rm_fresh_data", out_data, {32'h61, 32'h51});
    chk("rm_fresh_idx", out_row_idx, 2'd0);
    out_ready = 1'b1;
    tick();

    // Randomized traffic at several sink-readiness levels
    for (int ph = 0; ph < 4; ph++) begin
      ready_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 70;
      for (int c = 0; c < 600; c++) begin
        reset     = ($urandom_range(0, 249) == 0);
        in_valid  = ($urandom_range(0, 99) < 60);
        in_sum[0] = $urandom;
        in_sum[1] = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        tick();
      end
      do_reset();
    end

    // Streaming on the 4x4 instance: 8 back-to-back rows
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    chk("b_rst_valid", b_out_valid, 1'b0);
    b_rows  = 0;
    b_dones = 0;
    for (int c = 0; c < 20; c++) begin
      b_in_valid = (c < 8);
      for (int j = 0; j < int'(NB); j++) begin
        if (c - j >= 0 && c - j < 8) b_in_sum[j] = W'(256 * (c - j) + j);
        else b_in_sum[j] = $urandom;
      end
      chk("b_valid", b_out_valid, (c >= 4) && (c < 12));
      if (b_out_valid) begin
        chk("b_data", b_out_data, {W'(256 * b_rows + 3), W'(256 * b_rows + 2),
                                   W'(256 * b_rows + 1), W'(256 * b_rows)});
        chk("b_idx", b_out_row_idx, b_rows % 4);
        chk("b_last", b_out_last, (b_rows % 4) == 3);
        b_rows++;
      end
      if (b_done) b_dones++;
      tick();
    end
    chk("b_rows", b_rows, 8);
    chk("b_dones", b_dones, 2);
    chk("b_overflow", b_overflow, 1'b0);
    chk("b_in_ready", b_in_ready, 1'b1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_deskewer.md
Name: output_deskewer

Overview:
- Receive end of the systolic datapath; the mirror of the input skewer.
- Takes skewed column sums from the bottom of the systolic array, where column j of a row arrives j cycles after column 0.
- Realigns each row with per-column delay lines and buffers complete rows in a FIFO.
- Hands rows to the result store over a valid/ready handshake and pulses done after every MATRIX_SIZE rows (one full result matrix).

Parameters:
- MATRIX_SIZE, 2, array dimension N: columns per row and rows per matrix (N >= 1).
- DATA_SIZE, 32, bit width of each sum.
- FIFO_DEPTH, 2 (= MATRIX_SIZE), number of aligned rows buffered (>= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  column 0 of a new row is present on in_sum[0] this cycle.
- in_sum  input  [DATA_SIZE-1:0] x MATRIX_SIZE  skewed column sums from the array.
- in_ready  output  1  FIFO count plus rows in flight < FIFO_DEPTH (advisory to the scheduler).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  [DATA_SIZE-1:0] x MATRIX_SIZE  head row, aligned, column order preserved.
- out_row_idx  output  $clog2(MATRIX_SIZE)+1  row index within matrix of the head row.
- out_last  output  1  head row is row N-1 of its matrix.
- done  output  1  one-cycle pulse when the last row of a matrix is popped.
- overflow  output  1  sticky: an aligned row was dropped.

Behaviour:
- Reset, synchronous: FIFO emptied, rd/wr pointers 0, in-flight valid shift register cleared, row counters 0, overflow 0, done 0, out_valid 0, out_data 0.
- Reset mid-operation discards all buffered and in-flight rows.
- Skew model:
  - A row with in_valid in cycle k has column j valid in cycle k+j.
  - in_valid is asserted for a row's column 0 only; columns 1..N-1 carry no valid of their own.
- Alignment:
  - Column j passes through a register delay line of length N-1-j; column N-1 is unregistered.
  - A valid shift register of length N-1 tracks in_valid.
  - The aligned row is complete in cycle k+N-1 and is written to the FIFO on the edge ending that cycle.
- Latency:
  - out_valid rises in cycle k+N when the FIFO was empty (N=2: in_valid in cycle 0 gives out_valid in cycle 2).
  - N=1: write on the same edge that samples in_valid.
  - No combinational bypass from in_sum to out_data.
- Back-to-back rows: in_valid may be high every cycle; the delay lines are fully pipelined and accept one row per cycle.
- Pop handshake:
  - Pop occurs on an edge where out_valid && out_ready.
  - out_data, out_row_idx and out_last hold stable while out_valid && !out_ready.
- Full FIFO:
  - Write with FIFO full and no pop that cycle: row dropped, overflow set (stays set until reset), FIFO contents unchanged.
  - Write and pop on the same edge while full: both succeed, count unchanged.
- Empty FIFO: write and no pop gives count+1; out_ready is ignored while empty.
- Pointers wrap modulo FIFO_DEPTH; the count register distinguishes full from empty.
- Row indexing:
  - A write-side row counter tags each row 0..N-1 and wraps.
  - Dropped rows still advance the counter, so matrix framing holds.
- done:
  - Asserted for exactly one cycle following the edge that pops a row with out_last=1.
  - out_last is combinational from the head entry's tag.
- in_ready:
  - Low when count + popcount(in-flight valid bits) >= FIFO_DEPTH.
  - The block does not stall on it; the upstream is responsible for honouring it.
- Arithmetic: none on data; values pass bit-exact, and width is preserved.

Test Plan:
- N=2, DATA_SIZE=32, out_ready=1:
  - Stimulus: cycle0 in_valid=1, in_sum[0]=0x11; cycle1 in_sum[1]=0x21; cycle1 in_valid=1, in_sum[0]=0x12; cycle2 in_sum[1]=0x22.
  - Required: cycle2 out_data={0x11,0x21}, idx0; cycle3 out_data={0x12,0x22}, idx1, out_last=1; done=1 in cycle4, then 0.
- Backpressure:
  - Stimulus: out_ready=0, same two rows.
  - Required: out_valid=1 from cycle2; head {0x11,0x21} stable; in_ready=0 once count=2; raising out_ready pops rows in order.
- Overflow:
  - Stimulus: out_ready=0, third row {0x13,0x23} pushed into a full FIFO.
  - Required: overflow=1 persists; popped data contains only rows 0x11 and 0x12; the next accepted row carries idx1 (counter advanced by the drop).
- Simultaneous events:
  - Stimulus: FIFO full and out_ready=1 on the same cycle a row completes.
  - Required: pop {0x11,0x21} and write of the new row both occur; overflow stays 0; count stays 2.
- Reset mid-operation:
  - Stimulus: assert reset for one cycle with one row buffered and one row in flight.
  - Required: the next cycle shows out_valid=0, overflow=0, done=0; a fresh row afterwards gets idx0 with N-cycle latency.
- Continuous streaming:
  - Stimulus: N=4, 8 rows with in_valid held high; row r, column j carries value 0x100*r+j.
  - Required: out_data exact; done pulses twice; no overflow with out_ready=1.
